// File: rtl/spi_mem_pkg.sv
// Shared opcodes and FSM encoding for the serial-SRAM SPI master.
package spi_mem_pkg;
  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/spi_shift_engine.sv
// SCK divider plus N-bit MSB-first TX shifter and data-phase RX shifter (SPI mode 0).
// o_last flags the cycle whose clock edge ends the high phase of the final bit.
module spi_shift_engine #(
  parameter int N        = 24,
  parameter int RX_W     = 8,
  parameter int RX_START = 16,
  parameter int CLK_DIV  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [N-1:0]    i_frame,
  input  logic            i_miso,
  output logic            o_sck,
  output logic            o_mosi,
  output logic            o_last,
  output logic [RX_W-1:0] o_rx_dat
);
  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic          r_run;
  logic          r_sck;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [N-1:0]  r_tx;
  logic [RX_W-1:0] r_rx;

  logic w_tick;
  assign w_tick   = r_run && (r_div == DW'(CLK_DIV - 1));
  assign o_last   = w_tick && r_sck && (r_bit == BW'(N - 1));
  assign o_sck    = r_sck;
  assign o_mosi   = r_tx[N-1];
  assign o_rx_dat = r_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_sck <= 1'b0;
      r_div <= '0;
      r_bit <= '0;
      r_tx  <= '0;
      r_rx  <= '0;
    end else if (i_load) begin
      r_run <= 1'b1;
      r_sck <= 1'b0;
      r_div <= '0;
      r_bit <= '0;
      r_tx  <= i_frame;
    end else if (r_run) begin
      if (w_tick) begin
        r_div <= '0;
        r_sck <= ~r_sck;
        if (!r_sck) begin
          // Rising SCK: only opcode/address bits are skipped on receive.
          if (r_bit >= BW'(RX_START))
            r_rx <= {r_rx[RX_W-2:0], i_miso};
        end else begin
          // Falling SCK: the final shift empties r_tx so mosi idles low.
          r_tx <= {r_tx[N-2:0], 1'b0};
          if (o_last) r_run <= 1'b0;
          else        r_bit <= r_bit + 1'b1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for 23LC-style serial SRAM: READ/WRITE bursts with start/busy/done handshake.
// Owns the transaction FSM, chip select, inter-frame gap and the read-data register.
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 1,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    we,
  input  logic [8*ADDR_BYTES-1:0] addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    busy,
  output logic                    done,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    spi_cs_n,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);
  localparam int N  = 8 * (1 + ADDR_BYTES + DATA_BYTES);
  localparam int DW = 8 * DATA_BYTES;
  localparam int GW = $clog2(CS_GAP + 1);

  state_t        r_state;
  logic          r_we;
  logic          r_busy;
  logic          r_done;
  logic          r_cs_n;
  logic [GW-1:0] r_gap;
  logic [DW-1:0] r_rdata;

  logic          w_accept;
  logic          w_last;
  logic [N-1:0]  w_frame;
  logic [DW-1:0] w_rx;

  // The done cycle is still treated as busy so a start there is dropped.
  assign w_accept = (r_state == IDLE) && start && !r_done;
  assign w_frame  = {(we ? OPC_WRITE : OPC_READ), addr, (we ? wdata : {DW{1'b0}})};

  spi_shift_engine #(
    .N        (N),
    .RX_W     (DW),
    .RX_START (8 * (1 + ADDR_BYTES)),
    .CLK_DIV  (CLK_DIV)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_frame  (w_frame),
    .i_miso   (spi_miso),
    .o_sck    (spi_sck),
    .o_mosi   (spi_mosi),
    .o_last   (w_last),
    .o_rx_dat (w_rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_gap   <= '0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= we;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_cs_n  <= 1'b1;
            r_gap   <= '0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_gap == GW'(CS_GAP - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            if (!r_we) r_rdata <= w_rx;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign spi_cs_n = r_cs_n;
endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench: default instance (A) on a 256-byte RAM model, plus a
// DATA_BYTES=2 / CLK_DIV=1 instance (B) on a read-only pattern model.
module tb_spi_mem_master;
  logic clk;
  logic rst_n;

  logic        start_a, we_a, busy_a, done_a, cs_n_a, sck_a, mosi_a, miso_a;
  logic [7:0]  addr_a, wdata_a, rdata_a;
  logic        start_b, we_b, busy_b, done_b, cs_n_b, sck_b, mosi_b, miso_b;
  logic [7:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;

  int n_chk = 0;
  int n_err = 0;

  spi_mem_master u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .spi_cs_n(cs_n_a), .spi_sck(sck_a),
    .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  spi_mem_master #(.ADDR_BYTES(1), .DATA_BYTES(2), .CLK_DIV(1), .CS_GAP(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .spi_cs_n(cs_n_b), .spi_sck(sck_b),
    .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model A: samples mosi on SCK rise, drives miso on SCK fall, auto-increments.
  logic [7:0]  mem_a [256];
  logic [7:0]  sh_a, op_a, ad_a;
  logic [23:0] frm_a;
  int          bc_a, ia;
  always @(negedge cs_n_a or posedge sck_a) begin
    if (!sck_a) bc_a = 0;
    else begin
      sh_a  = {sh_a[6:0], mosi_a};
      frm_a = {frm_a[22:0], mosi_a};
      bc_a++;
      if (bc_a == 8)  op_a = sh_a;
      if (bc_a == 16) ad_a = sh_a;
      if (bc_a > 16 && bc_a % 8 == 0 && op_a == 8'h02)
        mem_a[8'(int'(ad_a) + (bc_a - 24) / 8)] = sh_a;
    end
  end
  always @(negedge sck_a) begin
    if (op_a == 8'h03 && bc_a >= 16) begin
      ia = bc_a - 16;
      miso_a = mem_a[8'(int'(ad_a) + ia / 8)][7 - ia % 8];
    end
  end

  // Pattern model B: 0x20=DE, 0x21=AD, elsewhere addr^5A.
  function automatic logic [7:0] rom_b(input logic [7:0] a);
    if (a == 8'h20) return 8'hDE;
    if (a == 8'h21) return 8'hAD;
    return a ^ 8'h5A;
  endfunction
  logic [7:0] sh_b, op_b, ad_b, byte_b;
  int         bc_b, ib;
  always @(negedge cs_n_b or posedge sck_b) begin
    if (!sck_b) bc_b = 0;
    else begin
      sh_b = {sh_b[6:0], mosi_b};
      bc_b++;
      if (bc_b == 8)  op_b = sh_b;
      if (bc_b == 16) ad_b = sh_b;
    end
  end
  always @(negedge sck_b) begin
    if (op_b == 8'h03 && bc_b >= 16) begin
      ib = bc_b - 16;
      byte_b = rom_b(8'(int'(ad_b) + ib / 8));
      miso_b = byte_b[7 - ib % 8];
    end
  end

  // Pulse/edge monitors sampled mid-cycle.
  int     dcnt_a = 0, cfall_a = 0, hi_run_a = 0, last_hi_a = 0;
  logic   cs_prev_a = 1'b1;
  always @(negedge clk) begin
    if (done_a) dcnt_a++;
    if (cs_prev_a && !cs_n_a) cfall_a++;
    cs_prev_a = cs_n_a;
    if (cs_n_a) hi_run_a++;
    else begin
      if (hi_run_a > 0) last_hi_a = hi_run_a;
      hi_run_a = 0;
    end
  end
  longint last_ra = 0, per_a = 0, last_rb = 0, per_b = 0;
  always @(posedge sck_a) begin per_a = ($time - last_ra) / 10; last_ra = $time; end
  always @(posedge sck_b) begin per_b = ($time - last_rb) / 10; last_rb = $time; end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input int sel, input logic s);
    if (sel == 0) start_a = s; else start_b = s;
  endtask

  // Issue one request; report cycle (relative to the start cycle t0) of done and of cs_n rising.
  task automatic run_txn(input int sel, input logic w, input logic [7:0] a, input logic [15:0] wd,
                         input int pulse_at, input int rst_at, output int t_done, output int t_csr);
    int k;
    t_done = -1;
    t_csr  = -1;
    @(posedge clk); #1;
    if (sel == 0) begin we_a = w; addr_a = a; wdata_a = wd[7:0]; end
    else begin we_b = w; addr_b = a; wdata_b = wd; end
    drive_start(sel, 1'b1);
    @(posedge clk); #1;
    drive_start(sel, 1'b0);
    // Disturb the held inputs; the frame in flight must not change.
    we_a = ~we_a; addr_a = ~addr_a; wdata_a = ~wdata_a;
    we_b = ~we_b; addr_b = ~addr_b; wdata_b = ~wdata_b;
    k = 1;
    while (k < 400 && t_done < 0) begin
      drive_start(sel, k == pulse_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        break;
      end
      if (t_csr < 0 && ((sel == 0) ? cs_n_a : cs_n_b)) t_csr = k;
      if ((sel == 0) ? done_a : done_b) t_done = k;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    drive_start(sel, 1'b0);
  endtask

  int td, tc, d0, c0;

  initial begin
    rst_n = 1'b0;
    start_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; miso_a = 0;
    start_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; miso_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_rdata", rdata_a, 0);
    check_val("rst_cs_n", cs_n_a, 1);
    check_val("rst_sck", sck_a, 0);
    check_val("rst_mosi", mosi_a, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Seed the RAM through the master, then read it back.
    run_txn(0, 1'b1, 8'h12, 16'h00A5, -1, -1, td, tc);
    check_val("wr12_done_t", td, 99);
    check_val("wr12_frame", frm_a, 24'h0212A5);
    check_val("wr12_rdata_kept", rdata_a, 0);
    repeat (4) @(posedge clk);
    run_txn(0, 1'b0, 8'h12, 16'h0, -1, -1, td, tc);
    check_val("rd12_done_t", td, 99);
    check_val("rd12_csr_t", tc, 97);
    check_val("rd12_rdata", rdata_a, 8'hA5);
    check_val("rd12_frame", frm_a, 24'h031200);
    check_val("sck_period_a", per_a, 4);

    // Write then read another location; the write must leave rdata alone.
    repeat (4) @(posedge clk);
    run_txn(0, 1'b1, 8'h40, 16'h003C, -1, -1, td, tc);
    check_val("wr40_done_t", td, 99);
    check_val("wr40_rdata_kept", rdata_a, 8'hA5);
    repeat (4) @(posedge clk);
    run_txn(0, 1'b0, 8'h40, 16'h0, -1, -1, td, tc);
    check_val("rd40_rdata", rdata_a, 8'h3C);

    // Start while busy is dropped.
    repeat (4) @(posedge clk);
    d0 = dcnt_a; c0 = cfall_a;
    run_txn(0, 1'b0, 8'h12, 16'h0, 10, -1, td, tc);
    check_val("busy_start_done_t", td, 99);
    check_val("busy_start_rdata", rdata_a, 8'hA5);
    repeat (120) @(posedge clk);
    #1;
    check_val("busy_start_dones", dcnt_a - d0, 1);
    check_val("busy_start_csfalls", cfall_a - c0, 1);
    check_val("busy_start_idle", busy_a, 0);

    // Reset mid-frame.
    d0 = dcnt_a;
    run_txn(0, 1'b0, 8'h40, 16'h0, -1, 50, td, tc);
    #1;
    check_val("midrst_cs_n", cs_n_a, 1);
    check_val("midrst_sck", sck_a, 0);
    check_val("midrst_busy", busy_a, 0);
    check_val("midrst_rdata", rdata_a, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("midrst_no_done", dcnt_a - d0, 0);
    run_txn(0, 1'b0, 8'h12, 16'h0, -1, -1, td, tc);
    check_val("postrst_done_t", td, 99);
    check_val("postrst_rdata", rdata_a, 8'hA5);

    // Back-to-back: second start in the cycle after done. cs_n is high for
    // the CS_GAP cycles, the done cycle and the restart cycle: CS_GAP+2 = 4.
    run_txn(0, 1'b0, 8'h40, 16'h0, -1, -1, td, tc);
    check_val("b2b_first_rdata", rdata_a, 8'h3C);
    run_txn(0, 1'b0, 8'h12, 16'h0, -1, -1, td, tc);
    check_val("b2b_second_done_t", td, 99);
    check_val("b2b_second_rdata", rdata_a, 8'hA5);
    check_val("b2b_cs_high", last_hi_a, 4);
    check_val("b2b_cs_high_min", (last_hi_a >= 2) ? 1 : 0, 1);

    // Two-byte burst at CLK_DIV=1: N=32, done at 1+64+2.
    run_txn(1, 1'b0, 8'h20, 16'h0, -1, -1, td, tc);
    check_val("b_done_t", td, 67);
    check_val("b_csr_t", tc, 65);
    check_val("b_rdata", rdata_b, 16'hDEAD);
    check_val("sck_period_b", per_b, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
